// File: rtl/mbisr_remap.sv
// ============================================================================
// Module   : mbisr_remap
// Purpose  : MBIST-driven fault table that redirects faulty SRAM words to spares
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mbisr_remap #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int SPARES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              fail_valid,
    input  logic [ADDR_W-1:0] fail_addr,
    input  logic              acc_en,
    input  logic              acc_we,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic [DATA_W-1:0] acc_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        used_count,
    output logic              overflow,
    output logic              repair_ok
);

    localparam int C_IDX_W = (SPARES > 1) ? $clog2(SPARES) : 1;
    localparam logic [3:0] C_SPARES_CNT = 4'(SPARES);

    logic              valid_q [SPARES];
    logic [ADDR_W-1:0] addr_q  [SPARES];
    logic [DATA_W-1:0] spare_q [SPARES];
    logic [3:0]        used_count_q;
    logic              overflow_q;

    // Read-data path: pending flag, source select, captured spare word, hold value
    logic              rd_pend_q;
    logic              sel_spare_q;
    logic [DATA_W-1:0] spare_rd_q;
    logic [DATA_W-1:0] hold_q;

    logic               w_hit;
    logic [C_IDX_W-1:0] w_hit_idx;
    logic               w_dup;
    logic               w_free;
    logic [C_IDX_W-1:0] w_free_idx;
    logic               w_alloc;
    logic               w_rd_req;

    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_dup      = 1'b0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int i = 0; i < SPARES; i++) begin
            if (valid_q[i] && (addr_q[i] == acc_addr)) begin
                w_hit     = acc_en;
                w_hit_idx = i[C_IDX_W-1:0];
            end
            if (valid_q[i] && (addr_q[i] == fail_addr)) begin
                w_dup = 1'b1;
            end
        end
        // Descending scan so the lowest free index is the one that sticks
        for (int i = SPARES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                w_free     = 1'b1;
                w_free_idx = i[C_IDX_W-1:0];
            end
        end
    end

    assign w_alloc  = fail_valid && !clr && !w_dup && w_free;
    assign w_rd_req = acc_en && !acc_we;

    assign mem_en    = acc_en && !w_hit;
    assign mem_we    = acc_en && acc_we && !w_hit;
    assign mem_addr  = acc_addr;
    assign mem_wdata = acc_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SPARES; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
                spare_q[i] <= '0;
            end
            used_count_q <= 4'd0;
            overflow_q   <= 1'b0;
        end else begin
            if (clr) begin
                for (int i = 0; i < SPARES; i++) begin
                    valid_q[i] <= 1'b0;
                end
                used_count_q <= 4'd0;
                overflow_q   <= 1'b0;
            end else if (w_alloc) begin
                valid_q[w_free_idx] <= 1'b1;
                addr_q[w_free_idx]  <= fail_addr;
                if (used_count_q != C_SPARES_CNT) begin
                    used_count_q <= used_count_q + 4'd1;
                end
            end else if (fail_valid && !w_dup) begin
                overflow_q <= 1'b1;
            end
            if (w_hit && acc_we) begin
                spare_q[w_hit_idx] <= acc_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q   <= 1'b0;
            sel_spare_q <= 1'b0;
            spare_rd_q  <= '0;
            hold_q      <= '0;
        end else begin
            rd_pend_q <= w_rd_req;
            if (w_rd_req) begin
                sel_spare_q <= w_hit;
                spare_rd_q  <= spare_q[w_hit_idx];
            end
            if (rd_pend_q) begin
                hold_q <= acc_rdata;
            end
        end
    end

    assign acc_rdata  = rd_pend_q ? (sel_spare_q ? spare_rd_q : mem_rdata) : hold_q;
    assign used_count = used_count_q;
    assign overflow   = overflow_q;
    assign repair_ok  = ~overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_mbisr_remap.sv
// ============================================================================
// Module   : tb_mbisr_remap
// Purpose  : scoreboard bench for mbisr_remap with a 1-cycle-latency SRAM model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mbisr_remap;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       fail_valid;
    logic [3:0] fail_addr;
    logic       acc_en;
    logic       acc_we;
    logic [3:0] acc_addr;
    logic [7:0] acc_wdata;
    logic [7:0] acc_rdata;
    logic       mem_en;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic [3:0] used_count;
    logic       overflow;
    logic       repair_ok;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [16];
    logic [7:0] exp_q [$];
    logic       rd_issue_q = 1'b0;

    mbisr_remap #(.ADDR_W(4), .DATA_W(8), .SPARES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .fail_valid (fail_valid),
        .fail_addr  (fail_addr),
        .acc_en     (acc_en),
        .acc_we     (acc_we),
        .acc_addr   (acc_addr),
        .acc_wdata  (acc_wdata),
        .acc_rdata  (acc_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .used_count (used_count),
        .overflow   (overflow),
        .repair_ok  (repair_ok)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = {i[3:0], i[3:0]};
        mem[5]  = 8'hA5;
        mem[12] = 8'hC2;
    end

    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
        if (mem_en && mem_we)  mem[mem_addr] <= mem_wdata;
        rd_issue_q <= acc_en && !acc_we;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every read issued last cycle must present its scoreboarded data now
    always @(negedge clk) begin
        if (rd_issue_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rdata_unexpected: got %0h with empty scoreboard", acc_rdata);
            end else begin
                chk("acc_rdata", {24'd0, acc_rdata}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic drive(input logic en, input logic we, input logic [3:0] a,
                         input logic [7:0] wd, input logic fv, input logic [3:0] fa,
                         input logic c);
        acc_en = en; acc_we = we; acc_addr = a; acc_wdata = wd;
        fail_valid = fv; fail_addr = fa; clr = c;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp, input logic fv,
                      input logic [3:0] fa);
        drive(1'b1, 1'b0, a, 8'd0, fv, fa, 1'b0);
        exp_q.push_back(exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_used", {28'd0, used_count}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_ok", {31'd0, repair_ok}, 32'd1);
        chk("rst_rdata", {24'd0, acc_rdata}, 32'd0);

        rd(4'd5, 8'hA5, 1'b0, 4'd0);
        @(negedge clk);
        chk("rd5_mem_en", {31'd0, mem_en}, 32'd1);
        chk("rd5_mem_addr", {28'd0, mem_addr}, 32'd5);
        step(); idle(); step();
        chk("rd5_used", {28'd0, used_count}, 32'd0);

        drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd3, 1'b0);
        step(); idle();
        chk("fail3_used", {28'd0, used_count}, 32'd1);
        drive(1'b1, 1'b1, 4'd3, 8'h3C, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        chk("wr3_mem_en", {31'd0, mem_en}, 32'd0);
        step();
        rd(4'd3, 8'h3C, 1'b0, 4'd0);
        @(negedge clk);
        chk("rd3_mem_en", {31'd0, mem_en}, 32'd0);
        step(); idle(); step();

        drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd3, 1'b0); step();
        drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd9, 1'b0); step();
        idle();
        chk("dup_used", {28'd0, used_count}, 32'd2);
        chk("dup_ovf", {31'd0, overflow}, 32'd0);
        drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd12, 1'b0); step();
        idle();
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_ok", {31'd0, repair_ok}, 32'd0);
        chk("ovf_used", {28'd0, used_count}, 32'd2);
        rd(4'd12, 8'hC2, 1'b0, 4'd0);
        @(negedge clk);
        chk("rd12_mem_en", {31'd0, mem_en}, 32'd1);
        step(); idle(); step();

        drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd4, 1'b1); step();
        idle();
        chk("clr_used", {28'd0, used_count}, 32'd0);
        chk("clr_ovf", {31'd0, overflow}, 32'd0);
        chk("clr_ok", {31'd0, repair_ok}, 32'd1);
        rd(4'd4, 8'h44, 1'b0, 4'd0);
        @(negedge clk);
        chk("rd4_mem_en", {31'd0, mem_en}, 32'd1);
        step();

        // Fault capture and read of the same address together: read still hits SRAM
        rd(4'd7, 8'h77, 1'b1, 4'd7);
        @(negedge clk);
        chk("rd7a_mem_en", {31'd0, mem_en}, 32'd1);
        step();
        // Entry 0 is reused and its spare word survived the clear
        rd(4'd7, 8'h3C, 1'b0, 4'd0);
        @(negedge clk);
        chk("rd7b_mem_en", {31'd0, mem_en}, 32'd0);
        step(); idle(); step();
        chk("rd7_used", {28'd0, used_count}, 32'd1);

        drive(1'b1, 1'b1, 4'd7, 8'h5A, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        chk("wr7_mem_en", {31'd0, mem_en}, 32'd0);
        step();
        rd(4'd7, 8'h00, 1'b0, 4'd0);
        step();
        idle();
        rst = 1'b1;
        #1;
        chk("arst_used", {28'd0, used_count}, 32'd0);
        chk("arst_rdata", {24'd0, acc_rdata}, 32'd0);
        step();
        rst = 1'b0;
        step();
        rd(4'd7, 8'h77, 1'b0, 4'd0);
        @(negedge clk);
        chk("post_rst_mem_en", {31'd0, mem_en}, 32'd1);
        step(); idle(); step(); step();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
